// File: rtl/data_mem_responder.sv
// Single-port word memory behind a valid/ready request port, answering each request
// after WAIT wait states. Define DATA_MEM_RESPONDER_MISALIGN_ERR_EN to flag misaligned accesses.
module data_mem_responder #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            c_we, c_mis;
  logic [AW-1:0]   c_idx;
  logic [31:0]     c_wdata;
  logic [3:0]      c_wstrb;
  logic [3:0][7:0] mem [DEPTH];

  logic            mis_in;
  logic            a_we, a_mis, go_resp;
  logic [AW-1:0]   a_idx;
  logic [31:0]     a_wdata;
  logic [3:0]      a_wstrb;

`ifdef DATA_MEM_RESPONDER_MISALIGN_ERR_EN
  logic err_q;
  assign mis_in  = |req_addr[1:0];
  assign rsp_err = err_q;
`else
  assign mis_in  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Upper address bits are ignored (accesses wrap modulo DEPTH).
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

  // With WAIT=0 the access happens on the accepting edge, so it must see the live request.
  always_comb begin
    if (state == IDLE) begin
      a_we    = req_we;
      a_idx   = req_addr[AW+1:2];
      a_wdata = req_wdata;
      a_wstrb = req_wstrb;
      a_mis   = mis_in;
    end else begin
      a_we    = c_we;
      a_idx   = c_idx;
      a_wdata = c_wdata;
      a_wstrb = c_wstrb;
      a_mis   = c_mis;
    end
    go_resp = (state == IDLE && req_valid && WAIT == 0) ||
              (state == BUSY && cnt == 4'd1);
  end

  // Storage is never cleared; a write commits only on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (rst && go_resp && a_we && !a_mis) begin
      for (int b = 0; b < 4; b++)
        if (a_wstrb[b]) mem[a_idx][b] <= a_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      c_we      <= 1'b0;
      c_mis     <= 1'b0;
      c_idx     <= '0;
      c_wdata   <= '0;
      c_wstrb   <= '0;
`ifdef DATA_MEM_RESPONDER_MISALIGN_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      rsp_valid <= go_resp;
      rsp_rdata <= (go_resp && !a_we && !a_mis) ? mem[a_idx] : 32'h0;
`ifdef DATA_MEM_RESPONDER_MISALIGN_ERR_EN
      err_q     <= go_resp && a_mis;
`endif
      case (state)
        IDLE: if (req_valid) begin
          c_we      <= req_we;
          c_mis     <= mis_in;
          c_idx     <= req_addr[AW+1:2];
          c_wdata   <= req_wdata;
          c_wstrb   <= req_wstrb;
          cnt       <= 4'(WAIT);
          state     <= (WAIT == 0) ? RESP : BUSY;
          req_ready <= 1'b0;
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench: instance 0 (WAIT=2) and instance 1 (WAIT=0) checked every cycle against a
// cycle-count/array model, plus literal expectations on directed transactions.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        rv [2];
  logic        we [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [3:0]  st [2];
  logic        rdy[2];
  logic        vl [2];
  logic [31:0] rd [2];
  logic        er [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .WAIT(2)) u0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(we[0]),
    .req_addr(ad[0]), .req_wdata(wd[0]), .req_wstrb(st[0]),
    .rsp_valid(vl[0]), .rsp_rdata(rd[0]), .rsp_err(er[0]));

  data_mem_responder #(.DEPTH(256), .WAIT(0)) u1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(we[1]),
    .req_addr(ad[1]), .req_wdata(wd[1]), .req_wstrb(st[1]),
    .rsp_valid(vl[1]), .rsp_rdata(rd[1]), .rsp_err(er[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [31:0] m_mem  [2][256];
  bit          m_known[2][256];
  bit          pend[2], p_we[2], p_mis[2];
  int          due[2], p_idx[2];
  logic [31:0] p_wd[2];
  logic [3:0]  p_st[2];
  bit          e_vl[2], e_er[2], e_rdy[2], e_chk[2];
  logic [31:0] e_rd[2];
  int          cyc = 0;

  function automatic int wait_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic commit(input int i);
    e_vl[i] = 1'b1;
    if (p_mis[i]) e_er[i] = 1'b1;
    else if (p_we[i]) begin
      for (int b = 0; b < 4; b++)
        if (p_st[i][b]) m_mem[i][p_idx[i]][8*b +: 8] = p_wd[i][8*b +: 8];
      if (p_st[i] == 4'hF) m_known[i][p_idx[i]] = 1'b1;
    end else begin
      e_rd[i]  = m_mem[i][p_idx[i]];
      e_chk[i] = m_known[i][p_idx[i]];
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        pend[i] = 0; e_vl[i] = 0; e_er[i] = 0; e_rd[i] = 0; e_chk[i] = 1; e_rdy[i] = 1;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        bit was;
        was = e_vl[i];
        e_vl[i] = 0; e_er[i] = 0; e_rd[i] = 0; e_chk[i] = 1;
        if (pend[i] && cyc == due[i]) begin
          pend[i] = 0;
          commit(i);
        end else if (!pend[i] && !was && rv[i]) begin
          p_we[i]  = we[i];
          p_idx[i] = (ad[i] >> 2) % 256;
          p_wd[i]  = wd[i];
          p_st[i]  = st[i];
`ifdef DATA_MEM_RESPONDER_MISALIGN_ERR_EN
          p_mis[i] = (ad[i] % 4) != 0;
`else
          p_mis[i] = 0;
`endif
          if (wait_of(i) == 0) commit(i);
          else begin
            pend[i] = 1;
            due[i]  = cyc + wait_of(i);
          end
        end
        e_rdy[i] = !pend[i] && !e_vl[i];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        chk($sformatf("rst_valid%0d", i), {31'b0, vl[i]}, 32'h0);
        chk($sformatf("rst_rdata%0d", i), rd[i], 32'h0);
        chk($sformatf("rst_err%0d", i), {31'b0, er[i]}, 32'h0);
      end else begin
        chk($sformatf("ready%0d", i), {31'b0, rdy[i]}, {31'b0, e_rdy[i]});
        chk($sformatf("valid%0d", i), {31'b0, vl[i]}, {31'b0, e_vl[i]});
        chk($sformatf("err%0d", i), {31'b0, er[i]}, {31'b0, e_er[i]});
        if (e_chk[i]) chk($sformatf("rdata%0d", i), rd[i], e_rd[i]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Called at posedge+2; returns at posedge+2 after the response.
  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] data, output logic err,
                     output int lat);
    rv[0] = 1; we[0] = w; ad[0] = a; wd[0] = d; st[0] = s;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rdy[0]) break;
    end
    @(posedge clk);
    #2 rv[0] = 0;
    lat = -1; data = 'x; err = 1'bx;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (vl[0]) begin
        lat = n; data = rd[0]; err = er[0];
        break;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic rq(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input string nm, input logic [31:0] exp_d);
    logic [31:0] data;
    logic        err;
    int          lat;
    req(w, a, d, s, data, err, lat);
    chk({nm, "_lat"}, lat, 32'd3);
    chk({nm, "_rdata"}, data, exp_d);
  endtask

  initial begin
    logic [31:0] data;
    logic        err;
    int          lat, n0, n1;
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; we[i] = 0; ad[i] = 0; wd[i] = 0; st[i] = 0;
    end
    repeat (3) @(posedge clk);
    #3 rst = 1;
    @(posedge clk);
    #2;

    rq(1, 32'h10, 32'hDEADBEEF, 4'hF, "wr10", 32'h0);
    rq(0, 32'h10, 32'h0, 4'h0, "rd10", 32'hDEADBEEF);
    rq(1, 32'h10, 32'h000000AA, 4'b0001, "wrb", 32'h0);
    rq(0, 32'h10, 32'h0, 4'h0, "rdb", 32'hDEADBEAA);
    rq(1, 32'h400, 32'h12345678, 4'hF, "wr400", 32'h0);
    rq(0, 32'h000, 32'h0, 4'h0, "rdwrap", 32'h12345678);
    rq(1, 32'h14, 32'h0BADF00D, 4'hF, "wr14", 32'h0);
    rq(1, 32'h14, 32'h55555555, 4'h0, "wrnostrb", 32'h0);
    rq(0, 32'h14, 32'h0, 4'h0, "rd14", 32'h0BADF00D);

    req(0, 32'h13, 32'h0, 4'h0, data, err, lat);
    chk("mis_lat", lat, 32'd3);
`ifdef DATA_MEM_RESPONDER_MISALIGN_ERR_EN
    chk("mis_err", {31'b0, err}, 32'd1);
    chk("mis_rdata", data, 32'h0);
`else
    chk("mis_err", {31'b0, err}, 32'd0);
    chk("mis_rdata", data, 32'hDEADBEAA);
`endif

    // Reset while the write to 0x20 sits in BUSY: it must be abandoned.
    rq(1, 32'h20, 32'h11112222, 4'hF, "wr20", 32'h0);
    rv[0] = 1; we[0] = 1; ad[0] = 32'h20; wd[0] = 32'hAAAA5555; st[0] = 4'hF;
    @(negedge clk);
    chk("pre_accept_ready", {31'b0, rdy[0]}, 32'd1);
    @(posedge clk);
    #2 rv[0] = 0; rst = 0;
    repeat (3) @(posedge clk);
    #3 rst = 1;
    @(posedge clk);
    #2;
    rq(0, 32'h20, 32'h0, 4'h0, "rd20", 32'h11112222);

    // Continuous req_valid on both instances; input changes mid-stream are allowed.
    rv[0] = 1; we[0] = 1; ad[0] = 32'h30; wd[0] = 32'h30303030; st[0] = 4'hF;
    rv[1] = 1; we[1] = 1; ad[1] = 32'h40; wd[1] = 32'hCAFE0001; st[1] = 4'hF;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (vl[0]) n0++;
      if (vl[1]) n1++;
      if (k == 6) begin
        @(posedge clk);
        #2 we[1] = 0;
      end
    end
    chk("b2b_w2_count", n0, 32'd3);
    chk("b2b_w0_count", n1, 32'd6);
    @(posedge clk);
    #2 rv[0] = 0; rv[1] = 0;
    repeat (6) @(posedge clk);
    #2;
    rq(0, 32'h30, 32'h0, 4'h0, "rd30", 32'h30303030);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d want 0", 1);
    $fatal(1);
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit storage words (power of two, at least 4).
REQ-002 SHALL have parameter WAIT, default 2, meaning the wait-state cycles inserted before each response (0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, meaning the core presents a request.
REQ-006 SHALL have port req_ready, output, 1, meaning the responder can accept a request this cycle.
REQ-007 SHALL have port req_we, input, 1, where 1 means write and 0 means read.
REQ-008 SHALL have port req_addr, input, 32, the byte address.
REQ-009 SHALL have port req_wdata, input, 32, the write data.
REQ-010 SHALL have port req_wstrb, input, 4, the byte-lane write enables; bit i covers bits 8i+7:8i.
REQ-011 SHALL have port rsp_valid, output, 1, a one-cycle response strobe.
REQ-012 SHALL have port rsp_rdata, output, 32, the read data, valid while rsp_valid is high.
REQ-013 SHALL have port rsp_err, output, 1, the error flag, valid while rsp_valid is high.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, BUSY, RESP.
REQ-015 SHALL drive req_ready high only in IDLE.
REQ-016 SHALL accept a request on an edge where req_valid and req_ready are both 1, capturing req_we, req_addr, req_wdata and req_wstrb into internal registers.
REQ-017 SHALL ignore req_* inputs outside IDLE; no queuing and no second outstanding request.
REQ-018 SHALL move IDLE to BUSY on accept when WAIT>0, loading a wait counter with WAIT; when WAIT=0, it SHALL move IDLE to RESP directly.
REQ-019 SHALL decrement the counter on each edge in BUSY and move to RESP on the edge where the counter equals 1.
REQ-020 SHALL perform the storage access on the edge entering RESP: a write updates only the strobed byte lanes; a read latches the addressed word into rsp_rdata.
REQ-021 SHALL assert rsp_valid for exactly one cycle (the RESP state), WAIT+1 cycles after the accepting edge, then return to IDLE; there is no response backpressure.
REQ-022 SHALL drive rsp_rdata to 0 for write responses, and hold it at 0 whenever rsp_valid is 0.
REQ-023 SHALL form the word index from req_addr[log2(DEPTH)+1:2]; higher address bits are ignored, so accesses wrap modulo DEPTH words.
REQ-024 SHALL perform no write when req_wstrb is 4'b0000, while still producing a normal response.
REQ-025 SHALL return the pre-write word when a read follows a write to the same word only if the write response has not yet completed; after the write response, a read SHALL return the new data.
REQ-026 SHALL ensure req_valid asserted in the RESP cycle is not accepted until the following IDLE cycle, giving a minimum spacing of WAIT+2 cycles between accepts.

Reset
REQ-027 SHALL, while rst=0, force the FSM to IDLE, the counter to 0, and req_ready=1 once released; rsp_valid=0, rsp_rdata=0 and rsp_err=0 SHALL hold during reset.
REQ-028 SHALL, on reset mid-transaction (BUSY or RESP), abandon the transaction with no response and no storage write unless that write already committed on the RESP entry edge.
REQ-029 SHALL NOT clear storage contents on reset.

Configuration
REQ-030 SHALL, when macro DATA_MEM_RESPONDER_MISALIGN_ERR_EN is defined, treat any accepted request with req_addr[1:0]!=0 as an error: no storage access, rsp_err=1 and rsp_rdata=0 in RESP, with the same latency as a normal response.
REQ-031 SHALL, when DATA_MEM_RESPONDER_MISALIGN_ERR_EN is undefined, ignore req_addr[1:0] and tie rsp_err to constant 0.

Verification
REQ-032 Write then read (WAIT=2): write addr 0x10, data 0xDEADBEEF, strb 0xF -> rsp_valid 3 cycles after accept, rdata 0; then read 0x10 -> rdata 0xDEADBEEF.
REQ-033 Byte strobe: word 0x10=0xDEADBEEF, write 0x000000AA with strb 4'b0001 -> a later read returns 0xDEADBEAA.
REQ-034 Wrap (DEPTH=256): write 0x400 with 0x12345678 -> a read of 0x000 returns 0x12345678.
REQ-035 Back-to-back and WAIT=0: req_valid held high continuously -> accepts every 2 cycles, rsp_valid 1 cycle after each accept, and req_ready=0 in RESP.
REQ-036 Reset mid-BUSY: assert rst=0 during a write to 0x20 before RESP -> no rsp_valid, and a later read of 0x20 returns the old value.
REQ-037 Misalignment, macro defined: read 0x13 -> rsp_err=1, rdata=0; macro undefined: the same read returns word 0x10 with rsp_err=0.
